// File: rtl/ram_arbiter.sv
// Registered, priority-scheduled access engine for the shared 64K x 8 RAM port (DMA, CPU, loader).
// Optional CPU write protection above WP_BASE is enabled by defining RAM_ARB_WPROT_EN.
module ram_arbiter #(
    parameter int unsigned   AW          = 16,
    parameter int unsigned   LD_MAX_WAIT = 15,
    parameter logic [AW-1:0] WP_BASE     = 16'hF000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_rd,
    input  logic          cpu_we,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ready,
    input  logic [AW-1:0] dma_addr,
    input  logic          dma_rd,
    output logic [7:0]    dma_dout,
    output logic          dma_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic          ld_wr,
    output logic          ld_wait,
    output logic          ld_ovf,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout
);

    localparam int unsigned CW = (LD_MAX_WAIT < 2) ? 1 : $clog2(LD_MAX_WAIT + 1);
    localparam logic [CW-1:0] CntMax = CW'(LD_MAX_WAIT);

`ifdef RAM_ARB_WPROT_EN
    localparam bit WpEn = 1'b1;
`else
    localparam bit WpEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;
    typedef enum logic [1:0] {SelNone, SelDma, SelCpu, SelLd} sel_e;

    state_e state_q, state_d;
    sel_e   gnt, sel_q;

    logic          cpu_rd_h, cpu_we_h, dma_rd_h;
    logic          cpu_pend_q, cpu_wr_q, dma_pend_q, ld_pend_q, ld_ovf_q;
    logic [AW-1:0] cpu_addr_q, dma_addr_q, ld_addr_q, acc_addr_q, gnt_addr;
    logic [7:0]    cpu_din_q, ld_data_q, acc_din_q;
    logic          acc_we_q;
    logic [7:0]    cpu_dout_q, dma_dout_q;
    logic          dma_valid_q;
    logic [CW-1:0] ld_cnt_q;

    logic cpu_rd_edge, cpu_we_edge, cpu_edge, dma_edge, starve, wp_hit, finish;

    assign cpu_rd_edge = cpu_rd & ~cpu_rd_h;
    assign cpu_we_edge = cpu_we & ~cpu_we_h;
    assign cpu_edge    = cpu_rd_edge | cpu_we_edge;
    assign dma_edge    = dma_rd & ~dma_rd_h;
    assign starve      = (ld_cnt_q == CntMax);
    assign wp_hit      = WpEn && (cpu_addr_q >= WP_BASE);
    assign finish      = (state_q != StIdle);

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant decision and next state; grants are only issued from idle
    always_comb begin
        gnt     = SelNone;
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (dma_pend_q) begin
                    gnt = SelDma;
                end else if (ld_pend_q && starve) begin
                    gnt = SelLd;
                end else if (cpu_pend_q) begin
                    gnt = SelCpu;
                end else if (ld_pend_q) begin
                    gnt = SelLd;
                end
                case (gnt)
                    SelDma:  state_d = StRd;
                    SelCpu:  state_d = cpu_wr_q ? StWr : StRd;
                    SelLd:   state_d = StWr;
                    default: state_d = StIdle;
                endcase
            end
            StRd, StWr: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs; the RAM address is presented in the grant cycle to meet its registered input
    always_comb begin
        case (gnt)
            SelDma:  gnt_addr = dma_addr_q;
            SelCpu:  gnt_addr = cpu_addr_q;
            SelLd:   gnt_addr = ld_addr_q;
            default: gnt_addr = acc_addr_q;
        endcase
        ram_addr  = gnt_addr;
        ram_din   = acc_din_q;
        ram_we    = (state_q == StWr) && acc_we_q;
        cpu_ready = !(cpu_pend_q || cpu_edge);
        cpu_dout  = cpu_dout_q;
        dma_dout  = dma_dout_q;
        dma_valid = dma_valid_q;
        ld_wait   = ld_pend_q;
        ld_ovf    = ld_ovf_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_rd_h    <= 1'b0;
            cpu_we_h    <= 1'b0;
            dma_rd_h    <= 1'b0;
            cpu_pend_q  <= 1'b0;
            cpu_wr_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_din_q   <= '0;
            dma_pend_q  <= 1'b0;
            dma_addr_q  <= '0;
            ld_pend_q   <= 1'b0;
            ld_addr_q   <= '0;
            ld_data_q   <= '0;
            ld_ovf_q    <= 1'b0;
            ld_cnt_q    <= '0;
            sel_q       <= SelNone;
            acc_addr_q  <= '0;
            acc_din_q   <= '0;
            acc_we_q    <= 1'b0;
            cpu_dout_q  <= '0;
            dma_dout_q  <= '0;
            dma_valid_q <= 1'b0;
        end else begin
            cpu_rd_h    <= cpu_rd;
            cpu_we_h    <= cpu_we;
            dma_rd_h    <= dma_rd;
            dma_valid_q <= 1'b0;

            if (cpu_edge && !cpu_pend_q) begin
                cpu_pend_q <= 1'b1;
                cpu_wr_q   <= cpu_we_edge;
                cpu_addr_q <= cpu_addr;
                cpu_din_q  <= cpu_din;
            end
            if (finish && sel_q == SelCpu) cpu_pend_q <= 1'b0;

            if (dma_edge && !dma_pend_q) begin
                dma_pend_q <= 1'b1;
                dma_addr_q <= dma_addr;
            end
            if (finish && sel_q == SelDma) dma_pend_q <= 1'b0;

            // A loader write that finds the buffer occupied is lost and flagged
            if (ld_wr) begin
                if (ld_pend_q) begin
                    ld_ovf_q <= 1'b1;
                end else begin
                    ld_pend_q <= 1'b1;
                    ld_addr_q <= ld_addr;
                    ld_data_q <= ld_data;
                end
            end
            if (finish && sel_q == SelLd) ld_pend_q <= 1'b0;

            if (gnt == SelLd) begin
                ld_cnt_q <= '0;
            end else if (ld_pend_q && !starve) begin
                ld_cnt_q <= ld_cnt_q + CW'(1);
            end

            if (gnt != SelNone) begin
                sel_q      <= gnt;
                acc_addr_q <= gnt_addr;
                acc_din_q  <= (gnt == SelLd) ? ld_data_q : cpu_din_q;
                acc_we_q   <= !(gnt == SelCpu && wp_hit);
            end

            if (state_q == StRd) begin
                if (sel_q == SelDma) begin
                    dma_dout_q  <= ram_dout;
                    dma_valid_q <= 1'b1;
                end else begin
                    cpu_dout_q <= ram_dout;
                end
            end
        end
    end

endmodule
